shift_sequencer: RTL and testbench

Multi-cycle shift controller for the integer datapath: sequences a 1-bit-per-cycle shift stage to execute SRL, SLL, SRA and ROR by a 5-bit amount. It sits between the decode/issue logic and the ALU result mux. It accepts one operation via a start pulse, iterates `shamt` single-bit steps, and presents the result with a one-cycle `done` pulse. It replaces a full barrel shifter where area matters more than latency.

---
 rtl/shift_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_shift_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift unit for the integer datapath. It is a small alternative to
// a full barrel shifter. One operation is accepted from IDLE. The working value
// is then shifted one bit per clock until the requested amount is used up. The
// result is presented with a single-cycle done pulse.
//
// Supported operations (i_op):
//   2'b00 SRL  logical right shift
//   2'b01 SLL  logical left shift
//   2'b10 SRA  arithmetic right shift
//   2'b11 ROR  rotate right
//
// Ports:
//   i_clk    single clock, rising-edge active
//   i_rst    asynchronous, active-high reset
//   i_start  operation request, sampled only in IDLE
//   i_flush  synchronous abort back to IDLE, no done is produced
//   i_op     operation select (see above)
//   i_in1    operand to shift
//   i_in2    shift amount source; only i_in2[SHAMT_W-1:0] is used
//   o_busy   high whenever the sequencer is not in IDLE
//   o_done   one-cycle pulse; o_out is valid while it is high
//   o_out    result register; holds until the next accepted start
//
// The accept cycle is IDLE with i_start=1 and i_flush=0. The operands only have
// to be stable in that cycle. A zero amount goes straight to DONE. Any other
// amount walks through SHIFT once per step. All outputs decode from registers,
// so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_out
);

  // The counter must be able to express every legal shift distance exactly.
  if (WIDTH != (32'd1 << SHAMT_W)) begin : g_bad_params
    $error("shift_sequencer: WIDTH must equal 2**SHAMT_W");
  end

  localparam logic [1:0] OpSrl = 2'b00;
  localparam logic [1:0] OpSll = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [1:0]         r_op;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_e             w_state_nxt;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_accept;
  logic               w_shifting;
  logic [WIDTH-1:0]   w_step;
  logic               w_unused_in2;

  assign w_shamt = i_in2[SHAMT_W-1:0];

  // Upper amount bits are ignored, which matches ISA semantics. There is no
  // saturation.
  assign w_unused_in2 = ^i_in2[WIDTH-1:SHAMT_W];

  // Flush overrides a start that arrives in the same cycle.
  assign w_accept = (r_state == StIdle) && i_start && !i_flush;

  // On a flush edge the partial value is frozen, not advanced.
  assign w_shifting = (r_state == StShift) && !i_flush;

  // ---------------------------------------------------------------------------
  // One-bit shift stage
  // ---------------------------------------------------------------------------
  always_comb begin
    w_step = r_acc;
    unique case (r_op)
      OpSrl:   w_step = {1'b0, r_acc[WIDTH-1:1]};
      OpSll:   w_step = {r_acc[WIDTH-2:0], 1'b0};
      OpSra:   w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      OpRor:   w_step = {r_acc[0], r_acc[WIDTH-1:1]};
      default: w_step = r_acc;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_nxt = (w_shamt == '0) ? StDone : StShift;
          end
        end
        StShift: begin
          if (r_cnt == SHAMT_W'(1)) begin
            w_state_nxt = StDone;
          end
        end
        StDone: begin
          w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        o_done = 1'b0;
      end
      StShift: begin
        o_busy = 1'b1;
        o_done = 1'b0;
      end
      StDone: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
        o_done = 1'b0;
      end
    endcase
  end

  assign o_out = r_acc;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_op  <= OpSrl;
    end else if (w_accept) begin
      r_acc <= i_in1;
      r_cnt <= w_shamt;
      r_op  <= i_op;
    end else if (w_shifting) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed testbench for shift_sequencer. It drives inputs 1 time unit after
// each rising edge and reads outputs at that same offset. Every expected value
// below was worked out by hand.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam logic [1:0] OpSrl = 2'b00;
  localparam logic [1:0] OpSll = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_done;

  shift_sequencer #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_flush (flush),
    .i_op    (op),
    .i_in1   (in1),
    .i_in2   (in2),
    .o_busy  (busy),
    .o_done  (done),
    .o_out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, as seen at each rising edge.
  initial n_done = 0;
  always @(posedge clk) begin
    if (done) n_done = n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, then check busy, done latency, result and return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] t_in1,
                        input logic [31:0] t_in2, input logic [31:0] exp_out,
                        input int exp_lat);
    int k;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    start = 1'b1;
    op    = t_op;
    in1   = t_in1;
    in2   = t_in2;
    step();                        // edge E0
    start = 1'b0;
    in1   = 32'hDEAD_BEEF;         // operands only need to hold in the accept cycle
    in2   = 32'h0000_0011;
    op    = ~t_op;
    check({tag, "_busy_after_e0"}, {31'd0, busy}, 32'd1);
    k = 0;
    while (!done && k < 40) begin
      step();
      k = k + 1;
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_out"}, out, exp_out);
    step();
    check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_cleared"}, {31'd0, busy}, 32'd0);
    check({tag, "_out_held"}, out, exp_out);
  endtask

  initial begin
    int k;
    int unsigned d0;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = OpSrl;
    in1   = '0;
    in2   = '0;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", out, 32'd0);
    rst = 1'b0;
    step();

    // Main function
    run_op("srl31", OpSrl, 32'h8000_0000, 32'd31,        32'h0000_0001, 31);
    run_op("sra36", OpSra, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4);
    run_op("sra4p", OpSra, 32'h7FFF_FFFF, 32'd4,         32'h07FF_FFFF, 4);
    run_op("sll0",  OpSll, 32'h1234_5678, 32'd0,         32'h1234_5678, 0);
    run_op("ror1",  OpRor, 32'h0000_0001, 32'd1,         32'h8000_0000, 1);
    run_op("ror8",  OpRor, 32'h1234_5678, 32'hFFFF_FFE8, 32'h7812_3456, 8);
    run_op("sll4",  OpSll, 32'h1234_5678, 32'd4,         32'h2345_6780, 4);
    run_op("srl4",  OpSrl, 32'hF0F0_F0F0, 32'd4,         32'h0F0F_0F0F, 4);

    // Starts during SHIFT and DONE are ignored
    d0    = n_done;
    start = 1'b1; op = OpSrl; in1 = 32'h0000_00F0; in2 = 32'd4;
    step();                                            // E0
    start = 1'b0;
    step();                                            // E1
    start = 1'b1; op = OpSll; in1 = 32'hFFFF_FFFF; in2 = 32'd3;
    step();                                            // E2, start ignored
    start = 1'b0;
    k = 2;
    while (!done && k < 40) begin
      step();
      k = k + 1;
    end
    check("ign_latency", k, 4);
    check("ign_out", out, 32'h0000_000F);
    start = 1'b1; op = OpRor; in1 = 32'h0000_0002; in2 = 32'd7;   // during DONE
    step();
    check("ign_done_start_busy", {31'd0, busy}, 32'd0);
    check("ign_one_pulse", n_done - d0, 32'd1);
    check("ign_out_kept", out, 32'h0000_000F);
    start = 1'b1; op = OpRor; in1 = 32'h0000_0001; in2 = 32'd1;   // first IDLE cycle
    step();
    start = 1'b0;
    check("idle_accept_busy", {31'd0, busy}, 32'd1);
    step();
    check("idle_accept_done", {31'd0, done}, 32'd1);
    check("idle_accept_out", out, 32'h8000_0000);
    step();

    // Flush mid-SHIFT after three steps
    d0    = n_done;
    start = 1'b1; op = OpSrl; in1 = 32'hFFFF_FFFF; in2 = 32'd8;
    step();                                            // E0
    start = 1'b0;
    step(); step(); step();                            // E1..E3
    flush = 1'b1;
    step();                                            // E4
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_out", out, 32'h1FFF_FFFF);
    for (int i = 0; i < 10; i++) step();
    check("flush_no_done", n_done - d0, 32'd0);
    check("flush_out_held", out, 32'h1FFF_FFFF);

    // Flush beats a simultaneous start in IDLE
    start = 1'b1; flush = 1'b1; op = OpSll; in1 = 32'h0000_0001; in2 = 32'd3;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    step();
    check("flush_start_busy2", {31'd0, busy}, 32'd0);
    check("flush_start_out", out, 32'h1FFF_FFFF);

    // Asynchronous reset mid-SHIFT
    d0    = n_done;
    start = 1'b1; op = OpSll; in1 = 32'h0000_0001; in2 = 32'd20;
    step();
    start = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_out", out, 32'd0);
    step();
    #3 rst = 1'b0;
    step();
    check("arst_no_done", n_done - d0, 32'd0);
    run_op("post_rst_sll5", OpSll, 32'h0000_0001, 32'd5, 32'h0000_0020, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
